// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result stream bundle for pipelined_cla_addsub.
// The slave side is the adder; the master side is whoever feeds and drains it.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Add/subtract unit built from 4-bit lookahead groups, one group resolved per
// pipeline stage, followed by an output register with valid/ready handshaking.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_cla_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / 4;

  function automatic logic [4:0] cla4(input logic [3:0] ga, input logic [3:0] gb,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = ga & gb;
    p    = ga | gb;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], ga ^ gb ^ c[3:0]};
  endfunction

  // Stage k holds full operands, sum bits for groups below k, and the carry into group k.
  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;

  logic             r_outValid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [STAGES:0]   w_adv;
  logic [WIDTH-1:0]  w_sNext [STAGES];
  logic [STAGES-1:0] w_cNext;
  logic [WIDTH-1:0]  w_bEff;
  logic              w_cIn;
  logic              w_ovf;

  assign w_bEff = bus.sub ? ~bus.b : bus.b;
  assign w_cIn  = bus.sub ? 1'b1 : bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_group
    logic [4:0] w_res;
    assign w_res      = cla4(r_a[k][4*k +: 4], r_b[k][4*k +: 4], r_c[k]);
    assign w_sNext[k] = r_s[k] | (WIDTH'(w_res[3:0]) << (4 * k));
    assign w_cNext[k] = w_res[4];
  end

  // A stage may move when it is empty or its successor is moving too.
  always_comb begin
    w_adv[STAGES] = !r_outValid || bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = !r_valid[k] || w_adv[k+1];
    end
  end

  assign w_ovf = (r_a[STAGES-1][WIDTH-1] == r_b[STAGES-1][WIDTH-1])
              && (w_sNext[STAGES-1][WIDTH-1] != r_a[STAGES-1][WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= '0;
      r_c        <= '0;
      r_outValid <= 1'b0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else begin
      if (w_adv[0]) begin
        r_valid[0] <= bus.in_valid;
        r_a[0]     <= bus.a;
        r_b[0]     <= w_bEff;
        r_s[0]     <= '0;
        r_c[0]     <= w_cIn;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_a[k]     <= r_a[k-1];
          r_b[k]     <= r_b[k-1];
          r_s[k]     <= w_sNext[k-1];
          r_c[k]     <= w_cNext[k-1];
        end
      end
      if (w_adv[STAGES]) begin
        r_outValid <= r_valid[STAGES-1];
        if (r_valid[STAGES-1]) begin
          r_sum  <= w_sNext[STAGES-1];
          r_cout <= w_cNext[STAGES-1];
          r_ovf  <= w_ovf;
        end
      end
    end
  end

  assign bus.in_ready  = w_adv[0];
  assign bus.out_valid = r_outValid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Directed bench for pipelined_cla_addsub at WIDTH=16: latency, arithmetic
// corner cases, streaming, backpressure and mid-flight reset.
module tb_pipelined_cla_addsub;
  localparam int WIDTH = 16;

  logic clk;
  logic rst;
  int   nCompared;
  int   nMismatched;

  pipelined_cla_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_addsub #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result packed as {ovf, cout, sum}, from plain wide addition.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    logic [15:0] be;
    logic [16:0] r;
    logic        o;
    be = msub ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + 17'(msub ? 1'b1 : mcin);
    o  = (ma[15] == be[15]) && (r[15] != ma[15]);
    return {o, r};
  endfunction

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 16'h0001;
    bus.b = 16'h0001;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({bus.out_valid, bus.ovf, bus.cout, bus.sum} !== 19'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got valid/ovf/cout/sum=%h required 0",
               {bus.out_valid, bus.ovf, bus.cout, bus.sum});
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    nCompared++;
    if (bus.in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    seen = 0;
    repeat (7) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    nCompared++;
    if (seen != 0) begin
      nMismatched++;
      $display("[TB] FAIL reset_inputs_ignored: got %0d valid cycles required 0", seen);
    end
  endtask

  task automatic test_single(input string name, input logic [15:0] ta, input logic [15:0] tb,
                             input logic tcin, input logic tsub, input logic [15:0] eSum,
                             input logic eCout, input logic eOvf);
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a = ta;
    bus.b = tb;
    bus.cin = tcin;
    bus.sub = tsub;
    bus.in_valid = 1'b1;
    #1;
    nCompared++;
    if (bus.in_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL %s_in_ready: got %b required 1", name, bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    nCompared++;
    if (lat != 4) begin
      nMismatched++;
      $display("[TB] FAIL %s_latency: got %0d cycles required 4", name, lat);
    end
    nCompared++;
    if ({bus.ovf, bus.cout, bus.sum} !== {eOvf, eCout, eSum}) begin
      nMismatched++;
      $display("[TB] FAIL %s_result: got ovf=%b cout=%b sum=%h required ovf=%b cout=%b sum=%h",
               name, bus.ovf, bus.cout, bus.sum, eOvf, eCout, eSum);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [6] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'hA5A5, 16'h0F0F, 16'h8000};
    logic [15:0] vb [6] = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h5A5A, 16'h00F1, 16'h7FFF};
    logic        vc [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [17:0] expQ[$];
    logic [17:0] exp;
    int sent = 0;
    int got = 0;
    int lastT = -1;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40 && got < 6; t++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        exp = (expQ.size() > 0) ? expQ.pop_front() : 18'h3FFFF;
        nCompared++;
        if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
          nMismatched++;
          $display("[TB] FAIL b2b_result%0d: got %h required %h", got,
                   {bus.ovf, bus.cout, bus.sum}, exp);
        end
        if (lastT >= 0) begin
          nCompared++;
          if (t != lastT + 1) begin
            nMismatched++;
            $display("[TB] FAIL b2b_no_bubble: got gap %0d required 1", t - lastT);
          end
        end
        lastT = t;
        got++;
      end
      if (sent < 6) begin
        bus.a = va[sent];
        bus.b = vb[sent];
        bus.cin = vc[sent];
        bus.sub = vs[sent];
        bus.in_valid = 1'b1;
        nCompared++;
        if (bus.in_ready !== 1'b1) begin
          nMismatched++;
          $display("[TB] FAIL b2b_in_ready: got %b required 1", bus.in_ready);
        end else begin
          expQ.push_back(model(va[sent], vb[sent], vc[sent], vs[sent]));
          sent++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    nCompared++;
    if (got != 6) begin
      nMismatched++;
      $display("[TB] FAIL b2b_count: got %0d results required 6", got);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF,
                            16'hDEAD, 16'h0000, 16'hC001, 16'h4444};
    logic [15:0] vb [8] = '{16'h4321, 16'h0001, 16'h8000, 16'h0001,
                            16'hBEEF, 16'h0001, 16'h4002, 16'h4444};
    logic        vc [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vs [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [17:0] expQ[$];
    logic [17:0] exp;
    logic [17:0] prevOut;
    bit prevStall = 1'b0;
    bit dropped = 1'b0;
    int sentAtDrop = 0;
    int sent = 0;
    int got = 0;
    for (int t = 0; t < 80 && got < 8; t++) begin
      @(negedge clk);
      bus.out_ready = (t < 6) ? 1'b0 : t[0];
      #1;
      if (prevStall) begin
        nCompared++;
        if (bus.out_valid !== 1'b1 || {bus.ovf, bus.cout, bus.sum} !== prevOut) begin
          nMismatched++;
          $display("[TB] FAIL bp_stall_hold: got valid=%b out=%h required valid=1 out=%h",
                   bus.out_valid, {bus.ovf, bus.cout, bus.sum}, prevOut);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        exp = (expQ.size() > 0) ? expQ.pop_front() : 18'h3FFFF;
        nCompared++;
        if ({bus.ovf, bus.cout, bus.sum} !== exp) begin
          nMismatched++;
          $display("[TB] FAIL bp_result%0d: got %h required %h", got,
                   {bus.ovf, bus.cout, bus.sum}, exp);
        end
        got++;
      end
      prevStall = (bus.out_valid === 1'b1) && !bus.out_ready;
      prevOut = {bus.ovf, bus.cout, bus.sum};
      if (t < 6 && bus.in_ready !== 1'b1 && !dropped) begin
        dropped = 1'b1;
        sentAtDrop = sent;
      end
      if (sent < 8) begin
        bus.a = va[sent];
        bus.b = vb[sent];
        bus.cin = vc[sent];
        bus.sub = vs[sent];
        bus.in_valid = 1'b1;
        if (bus.in_ready === 1'b1) begin
          expQ.push_back(model(va[sent], vb[sent], vc[sent], vs[sent]));
          sent++;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    nCompared++;
    if (!dropped || sentAtDrop < 4) begin
      nMismatched++;
      $display("[TB] FAIL bp_in_ready_drop: got dropped=%b after %0d ops required drop after >=4",
               dropped, sentAtDrop);
    end
    nCompared++;
    if (got != 8) begin
      nMismatched++;
      $display("[TB] FAIL bp_count: got %0d results required 8", got);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.a = 16'h1111 * 16'(i + 1);
      bus.b = 16'h0101;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    nCompared++;
    if (bus.out_valid !== 1'b0 || bus.sum !== 16'h0000) begin
      nMismatched++;
      $display("[TB] FAIL midreset_outputs: got valid=%b sum=%h required valid=0 sum=0000",
               bus.out_valid, bus.sum);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    nCompared++;
    if (seen != 0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_discard: got %0d valid cycles required 0", seen);
    end
    test_single("midreset_new", 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    test_reset();
    test_single("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_single("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    test_single("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    test_single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    test_single("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    test_single("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    test_single("sub_equal", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
